// File: rtl/alu_exec_pkg.sv
// alu_exec_pkg: alu_ctrl codes and execute-stage state shared with the ALU control decoder
package alu_exec_pkg;
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_SLL  = 4'b0011;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_ADDI = 4'b0100;
  localparam logic [3:0] ALU_EQ   = 4'b1111;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} alu_state_e;
  function automatic logic is_shift(input logic [3:0] c);
    return c == ALU_SLL || c == ALU_SRL;
  endfunction
endpackage

// File: rtl/alu_shift_iter.sv
// alu_shift_iter: one-bit-per-cycle logical shifter; done_o marks the cycle whose value_o is final
module alu_shift_iter
  import alu_exec_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             right_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [SHW-1:0]   amt_i,
  output logic             done_o,
  output logic [WIDTH-1:0] value_o
);
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             right_q, right_d, active_q, active_d;
  always_comb begin
    value_o  = right_q ? sh_q >> 1 : sh_q << 1;
    done_o   = active_q && cnt_q == SHW'(1);
    sh_d     = start_i ? data_i : active_q ? value_o : sh_q;
    cnt_d    = start_i ? amt_i : active_q ? cnt_q - SHW'(1) : cnt_q;
    right_d  = start_i ? right_i : right_q;
    active_d = start_i || (active_q && !done_o);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q     <= '0;
      cnt_q    <= '0;
      right_q  <= 1'b0;
      active_q <= 1'b0;
    end else begin
      sh_q     <= sh_d;
      cnt_q    <= cnt_d;
      right_q  <= right_d;
      active_q <= active_d;
    end
  end
endmodule

// File: rtl/alu_exec.sv
// alu_exec: execute-stage ALU with registered result/flags and valid/ready handshake
// Single-cycle ops finish at the accept edge; SLL/SRL with nonzero amount iterate in alu_shift_iter.
module alu_exec
  import alu_exec_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic             busy
);
  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d, alu_res, sum, diff, sh_value;
  logic             zero_q, zero_d, ovf_q, ovf_d, busy_q, busy_d;
  logic             alu_zero, alu_ovf, accept, start, sh_done;
  alu_shift_iter #(.WIDTH(WIDTH), .SHW(SHW)) u_shift (
    .clk    (clk),
    .rst    (rst),
    .start_i(start),
    .right_i(alu_ctrl == ALU_SRL),
    .data_i (src_b),
    .amt_i  (shamt),
    .done_o (sh_done),
    .value_o(sh_value)
  );
  // Shift codes here only cover shamt==0, where the result is src_b unchanged.
  always_comb begin
    sum  = src_a + src_b;
    diff = src_a - src_b;
    case (alu_ctrl)
      ALU_AND:           alu_res = src_a & src_b;
      ALU_OR:            alu_res = src_a | src_b;
      ALU_ADD, ALU_ADDI: alu_res = sum;
      ALU_SUB, ALU_EQ:   alu_res = diff;
      ALU_SLT:           alu_res = {{(WIDTH-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      ALU_NOR:           alu_res = ~(src_a | src_b);
      ALU_SLL, ALU_SRL:  alu_res = src_b;
      default:           alu_res = '0;
    endcase
    alu_zero = alu_ctrl == ALU_EQ ? src_a == src_b : alu_res == '0;
    alu_ovf  = (alu_ctrl == ALU_ADD || alu_ctrl == ALU_ADDI) ?
               (src_a[WIDTH-1] == src_b[WIDTH-1] && sum[WIDTH-1] != src_a[WIDTH-1]) :
               alu_ctrl == ALU_SUB ?
               (src_a[WIDTH-1] != src_b[WIDTH-1] && diff[WIDTH-1] != src_a[WIDTH-1]) : 1'b0;
  end
  always_comb begin
    in_ready = state_q == IDLE || (state_q == DONE && out_ready);
    accept   = in_valid && in_ready;
    start    = accept && is_shift(alu_ctrl) && shamt != '0;
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    if (accept) begin
      state_d  = start ? SHIFT : DONE;
      result_d = start ? result_q : alu_res;
      zero_d   = start ? zero_q : alu_zero;
      ovf_d    = start ? ovf_q : alu_ovf;
    end else if (state_q == SHIFT && sh_done) begin
      state_d  = DONE;
      result_d = sh_value;
      zero_d   = sh_value == '0;
      ovf_d    = 1'b0;
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
    busy_d = state_d == SHIFT;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
    end
  end
  assign out_valid = state_q == DONE;
  assign result    = result_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: directed vectors against a per-op arithmetic model with a latency-tracking scoreboard
module tb_alu_exec;
  import alu_exec_pkg::*;
  typedef struct packed {logic [31:0] r; logic z; logic o;} res_t;
  logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic [3:0]  alu_ctrl = '0;
  logic [31:0] src_a = '0, src_b = '0;
  logic [4:0]  shamt = '0;
  logic        in_ready, out_valid, zero, ovf, busy;
  logic [31:0] result;
  int          n_cmp = 0, n_bad = 0, cyc = 0, due = 0, lat = 0;
  bit          armed = 1'b0, pend = 1'b0, ev, eb, er;
  res_t        pr;

  alu_exec #(.WIDTH(32), .SHW(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .alu_ctrl(alu_ctrl),
    .src_a(src_a), .src_b(src_b), .shamt(shamt), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic res_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] s);
    longint sa = $signed(a), sb = $signed(b), t;
    res_t m;
    m.o = 1'b0;
    case (op)
      ALU_AND: m.r = a & b;
      ALU_OR:  m.r = a | b;
      ALU_NOR: m.r = ~(a | b);
      ALU_ADD, ALU_ADDI: begin
        t = sa + sb;
        m.r = a + b;
        m.o = t > 64'sd2147483647 || t < -64'sd2147483648;
      end
      ALU_SUB: begin
        t = sa - sb;
        m.r = a - b;
        m.o = t > 64'sd2147483647 || t < -64'sd2147483648;
      end
      ALU_EQ:  m.r = a - b;
      ALU_SLT: m.r = sa < sb ? 32'd1 : 32'd0;
      ALU_SLL: m.r = b << s;
      ALU_SRL: m.r = b >> s;
      default: m.r = 32'd0;
    endcase
    m.z = op == ALU_EQ ? a == b : m.r == 32'd0;
    return m;
  endfunction

  // Scoreboard: at most one op in flight; its result is due 1+n cycles after accept.
  always @(negedge clk) begin
    cyc++;
    if (armed) begin
      ev = pend && cyc >= due;
      eb = pend && cyc < due;
      er = !pend || (ev && out_ready);
      check("sb_out_valid", 32'(out_valid), 32'(ev));
      check("sb_busy", 32'(busy), 32'(eb));
      check("sb_in_ready", 32'(in_ready), 32'(er));
      if (ev) begin
        check("sb_result", result, pr.r);
        check("sb_zero", 32'(zero), 32'(pr.z));
        check("sb_ovf", 32'(ovf), 32'(pr.o));
      end
      if (rst) pend = 1'b0;
      else begin
        if (ev && out_ready) pend = 1'b0;
        if (in_valid && er) begin
          pend = 1'b1;
          pr   = model(alu_ctrl, src_a, src_b, shamt);
          due  = cyc + 1 + ((alu_ctrl == ALU_SLL || alu_ctrl == ALU_SRL) ? int'(shamt) : 0);
        end
      end
    end else if (rst) armed = 1'b1;
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] s);
    int w = 0;
    in_valid = 1'b1;
    alu_ctrl = op;
    src_a    = a;
    src_b    = b;
    shamt    = s;
    @(negedge clk);
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL issue_timeout: in_ready got 0 expected 1 op %b", op);
    end
    sync();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    alu_ctrl = 4'($urandom);
    src_a    = $urandom;
    src_b    = $urandom;
    shamt    = 5'($urandom);
  endtask

  task automatic wait_out();
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 64);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_result", result, 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    sync();
    issue(ALU_ADD, 32'h7FFF_FFFF, 32'h1, 5'd0);
    idle();
    @(negedge clk);
    check("add_out_valid", 32'(out_valid), 32'h1);
    check("add_result", result, 32'h8000_0000);
    check("add_ovf", 32'(ovf), 32'h1);
    check("add_zero", 32'(zero), 32'h0);
    sync();
    issue(ALU_SUB, 32'd5, 32'd5, 5'd0);
    issue(ALU_EQ, 32'h1234, 32'h1234, 5'd0);
    idle();
    @(negedge clk);
    check("eq_result", result, 32'h0);
    check("eq_zero", 32'(zero), 32'h1);
    sync();
    issue(ALU_SLL, 32'h0, 32'h1, 5'd31);
    idle();
    wait_out();
    check("sll31_latency", 32'(lat), 32'd32);
    check("sll31_result", result, 32'h8000_0000);
    sync();
    issue(ALU_SRL, 32'h0, 32'h8000_0000, 5'd4);
    idle();
    wait_out();
    check("srl4_latency", 32'(lat), 32'd5);
    check("srl4_result", result, 32'h0800_0000);
    sync();
    issue(ALU_SLT, 32'hFFFF_FFFF, 32'h1, 5'd0);
    idle();
    @(negedge clk);
    check("slt_neg_result", result, 32'h1);
    sync();
    out_ready = 1'b0;
    issue(ALU_SLT, 32'h1, 32'hFFFF_FFFF, 5'd0);
    in_valid = 1'b1;
    alu_ctrl = ALU_AND;
    src_a    = 32'hF0F0;
    src_b    = 32'hFF00;
    shamt    = 5'd0;
    repeat (5) begin
      @(negedge clk);
      check("hold_result", result, 32'h0);
      check("hold_in_ready", 32'(in_ready), 32'h0);
    end
    sync();
    out_ready = 1'b1;
    issue(ALU_AND, 32'hF0F0, 32'hFF00, 5'd0);
    idle();
    @(negedge clk);
    check("and_after_hold", result, 32'h0000_F000);
    sync();
    issue(ALU_SLL, 32'h0, 32'h3, 5'd20);
    idle();
    repeat (9) sync();
    rst = 1'b1;
    sync();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_result", result, 32'h0);
    check("midrst_in_ready", 32'(in_ready), 32'h1);
    repeat (30) begin
      @(negedge clk);
      check("midrst_no_valid", 32'(out_valid), 32'h0);
    end
    sync();
    issue(4'b1010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
    idle();
    @(negedge clk);
    check("undef_result", result, 32'h0);
    check("undef_zero", 32'(zero), 32'h1);
    check("undef_ovf", 32'(ovf), 32'h0);
    sync();
    issue(ALU_SLL, 32'h0, 32'hABCD_1234, 5'd0);
    idle();
    @(negedge clk);
    check("sll0_out_valid", 32'(out_valid), 32'h1);
    check("sll0_result", result, 32'hABCD_1234);
    sync();
    issue(ALU_OR, 32'h0F00_00F0, 32'h0000_0F0F, 5'd0);
    issue(ALU_NOR, 32'h0F0F_0F0F, 32'hF0F0_0000, 5'd0);
    issue(ALU_ADDI, 32'hFFFF_FFFE, 32'h5, 5'd0);
    issue(ALU_SUB, 32'h8000_0000, 32'h1, 5'd0);
    issue(ALU_SRL, 32'h0, 32'hFFFF_FFFF, 5'd1);
    issue(ALU_EQ, 32'h5, 32'h7, 5'd0);
    issue(ALU_ADD, 32'h8000_0000, 32'h8000_0000, 5'd0);
    issue(ALU_SLL, 32'h0, 32'h0000_8001, 5'd17);
    issue(ALU_SUB, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 5'd0);
    idle();
    repeat (40) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
